// File: rtl/dmem_arbiter_pkg.sv
// dmem_arbiter_pkg: state and owner encodings shared by the data-memory arbiter.
package dmem_arbiter_pkg;
  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_ACCESS = 2'd1,
    ARB_RESP   = 2'd2
  } arb_state_t;
  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_DMA = 1'b1
  } owner_t;
endpackage

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: grants CPU or DMA one access at a time to the shared data memory.
// Define DMEM_ARB_FAIR_EN for round-robin tie breaking on last_owner; default is fixed CPU priority.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 8,
  parameter int MEM_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_rd,
  input  logic              cpu_wr,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_done,
  output logic              cpu_stall,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic [DATA_W-1:0] dma_rdata,
  output logic              dma_ack,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_rd,
  output logic              mem_wr,
  input  logic [DATA_W-1:0] mem_rdata
);
`ifdef DMEM_ARB_FAIR_EN
  localparam logic fair = 1'b1;
`else
  localparam logic fair = 1'b0;
`endif
  localparam logic [2:0] lat_init = 3'(MEM_LAT - 1);
  arb_state_t state;
  owner_t owner, last_owner;
  logic [2:0] cnt;
  logic cpu_req, grant_dma;
  assign cpu_req   = cpu_rd | cpu_wr;
  assign grant_dma = dma_req & (~cpu_req | (fair & (last_owner == OWN_CPU)));
  assign cpu_stall = cpu_req & ~cpu_done;
  // The strobe registers double as the latched direction for the whole access.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ARB_IDLE;
      owner      <= OWN_CPU;
      last_owner <= OWN_DMA;
      cnt        <= '0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_rd     <= 1'b0;
      mem_wr     <= 1'b0;
      cpu_rdata  <= '0;
      dma_rdata  <= '0;
      cpu_done   <= 1'b0;
      dma_ack    <= 1'b0;
    end else begin
      case (state)
        ARB_IDLE: if (cpu_req | dma_req) begin
          owner      <= grant_dma ? OWN_DMA : OWN_CPU;
          last_owner <= grant_dma ? OWN_DMA : OWN_CPU;
          cnt        <= lat_init;
          mem_addr   <= grant_dma ? dma_addr : cpu_addr;
          mem_wdata  <= grant_dma ? dma_wdata : cpu_wdata;
          mem_wr     <= grant_dma ? dma_we : cpu_wr;
          mem_rd     <= grant_dma ? ~dma_we : ~cpu_wr;
          state      <= ARB_ACCESS;
        end
        ARB_ACCESS: if (cnt == 3'd0) begin
          if (mem_rd && owner == OWN_CPU) cpu_rdata <= mem_rdata;
          if (mem_rd && owner == OWN_DMA) dma_rdata <= mem_rdata;
          cpu_done  <= owner == OWN_CPU;
          dma_ack   <= owner == OWN_DMA;
          mem_rd    <= 1'b0;
          mem_wr    <= 1'b0;
          mem_addr  <= '0;
          mem_wdata <= '0;
          state     <= ARB_RESP;
        end else begin
          cnt <= cnt - 3'd1;
        end
        ARB_RESP: begin
          cpu_done <= 1'b0;
          dma_ack  <= 1'b0;
          state    <= ARB_IDLE;
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed and random CPU/DMA traffic checked against a transaction-level memory model.
module tb_dmem_arbiter;
  localparam int LAT = 3;
  logic clk = 1'b0;
  logic reset;
  logic cpu_rd, cpu_wr, dma_req, dma_we;
  logic [7:0] cpu_addr, cpu_wdata, dma_addr, dma_wdata;
  logic [7:0] cpu_rdata, dma_rdata, mem_addr, mem_wdata, mem_rdata;
  logic cpu_done, cpu_stall, dma_ack, mem_rd, mem_wr;
  int checks = 0;
  int errors = 0;
  logic [7:0] mem [256];
  logic [255:0] wr_valid = '0;
  logic [7:0] ref_mem [256];
  logic [7:0] exp_cpu_rdata, exp_dma_rdata;
  bit last_cpu;
  bit c_act, c_we, d_act, d_we;
  logic [7:0] c_addr, c_data, d_addr, d_data;

  always #5 clk = ~clk;

  dmem_arbiter #(.ADDR_W(8), .DATA_W(8), .MEM_LAT(LAT)) dut (
    .clk(clk), .reset(reset),
    .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_done(cpu_done), .cpu_stall(cpu_stall),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_rdata(dma_rdata), .dma_ack(dma_ack),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .mem_rdata(mem_rdata)
  );

  function automatic logic [7:0] init_val(logic [7:0] a);
    return a * 8'd37 + 8'd11;
  endfunction

  always @(posedge clk) if (mem_wr) begin
    mem[mem_addr] <= mem_wdata;
    wr_valid[mem_addr] <= 1'b1;
  end
  assign mem_rdata = mem_rd ? (wr_valid[mem_addr] ? mem[mem_addr] : init_val(mem_addr)) : 8'h00;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit winner();
    if (!c_act) return 1'b1;
    if (!d_act) return 1'b0;
`ifdef DMEM_ARB_FAIR_EN
    return last_cpu;
`else
    return 1'b0;
`endif
  endfunction

  // Follows one granted access from the idle cycle before the grant to the idle cycle after the pulse.
  task automatic serve(input bit dma);
    bit we;
    logic [7:0] a, wd;
    we = dma ? d_we : c_we;
    a  = dma ? d_addr : c_addr;
    wd = dma ? d_data : c_data;
    for (int i = 0; i < LAT; i++) begin
      @(posedge clk); #1;
      if (dma) begin
        dma_addr = 8'($urandom); dma_wdata = 8'($urandom); dma_we = 1'($urandom);
      end else begin
        cpu_addr = 8'($urandom); cpu_wdata = 8'($urandom);
      end
      chk("mem_wr", mem_wr, we);
      chk("mem_rd", mem_rd, !we);
      chk("mem_addr", mem_addr, a);
      if (we) chk("mem_wdata", mem_wdata, wd);
      chk("no_pulse_in_access", {cpu_done, dma_ack}, 0);
      chk("stall_in_access", cpu_stall, c_act);
    end
    @(posedge clk); #1;
    if (we) ref_mem[a] = wd;
    else if (dma) exp_dma_rdata = ref_mem[a];
    else exp_cpu_rdata = ref_mem[a];
    last_cpu = !dma;
    chk("cpu_done", cpu_done, !dma);
    chk("dma_ack", dma_ack, dma);
    chk("strobes_in_resp", {mem_rd, mem_wr}, 0);
    chk("cpu_rdata", cpu_rdata, exp_cpu_rdata);
    chk("dma_rdata", dma_rdata, exp_dma_rdata);
    chk("stall_in_resp", cpu_stall, c_act & dma);
    if (dma) begin dma_req = 1'b0; d_act = 1'b0; end
    else begin cpu_rd = 1'b0; cpu_wr = 1'b0; c_act = 1'b0; end
    @(posedge clk); #1;
    chk("idle_outputs", {cpu_done, dma_ack, mem_rd, mem_wr, mem_addr, mem_wdata}, 0);
  endtask

  task automatic step(input bit ca, input bit cw, input logic [7:0] caddr, input logic [7:0] cdata,
                      input bit da, input bit dw, input logic [7:0] daddr, input logic [7:0] ddata);
    c_act = ca; c_we = cw; c_addr = caddr; c_data = cdata;
    d_act = da; d_we = dw; d_addr = daddr; d_data = ddata;
    cpu_wr = ca & cw;
    cpu_rd = ca & (!cw | 1'($urandom));
    cpu_addr = caddr; cpu_wdata = cdata;
    dma_req = da; dma_we = dw; dma_addr = daddr; dma_wdata = ddata;
    while (c_act || d_act) serve(winner());
  endtask

  initial begin
    for (int i = 0; i < 256; i++) ref_mem[i] = init_val(8'(i));
    reset = 1'b1;
    cpu_rd = 1'b0; cpu_wr = 1'b1; cpu_addr = 8'h00; cpu_wdata = 8'h00;
    dma_req = 1'b0; dma_we = 1'b0; dma_addr = 8'h00; dma_wdata = 8'h00;
    @(posedge clk); #1;
    chk("reset_outputs", {cpu_done, dma_ack, mem_rd, mem_wr, mem_addr, mem_wdata, cpu_rdata, dma_rdata}, 0);
    chk("reset_stall_follows", cpu_stall, 1);
    cpu_wr = 1'b0; #1;
    chk("reset_stall_idle", cpu_stall, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    last_cpu = 1'b0; exp_cpu_rdata = 8'h00; exp_dma_rdata = 8'h00;
    step(1, 1, 8'h12, 8'hA5, 0, 0, 8'h00, 8'h00);
    step(1, 1, 8'h50, 8'h3C, 0, 0, 8'h00, 8'h00);
    step(1, 0, 8'h50, 8'h00, 0, 0, 8'h00, 8'h00);
    step(0, 0, 8'h00, 8'h00, 1, 0, 8'h12, 8'h00);
    step(1, 0, 8'h01, 8'h00, 1, 0, 8'h02, 8'h00);
    step(1, 0, 8'h01, 8'h00, 1, 0, 8'h02, 8'h00);
    step(0, 0, 8'h00, 8'h00, 1, 1, 8'h40, 8'h77);
    step(1, 1, 8'h41, 8'h99, 1, 1, 8'h41, 8'h66);
    // Reset lands on the second strobe cycle of a CPU read; the held request must be served afterwards.
    c_act = 1; c_we = 0; c_addr = 8'h50; d_act = 0;
    cpu_rd = 1'b1; cpu_wr = 1'b0; cpu_addr = 8'h50;
    @(posedge clk); #1;
    chk("rst_mid_rd_cycle1", mem_rd, 1);
    @(posedge clk); #1;
    reset = 1'b1; #1;
    chk("rst_mid_strobes", {mem_rd, mem_wr, mem_addr}, 0);
    chk("rst_mid_rdata", {cpu_rdata, dma_rdata}, 0);
    chk("rst_mid_no_done", cpu_done, 0);
    chk("rst_mid_stall", cpu_stall, 1);
    @(posedge clk); #1;
    chk("rst_mid_no_done_later", {cpu_done, mem_rd}, 0);
    reset = 1'b0;
    exp_cpu_rdata = 8'h00; exp_dma_rdata = 8'h00; last_cpu = 1'b0;
    serve(1'b0);
    for (int n = 0; n < 40; n++) begin
      bit ca, da;
      ca = 1'($urandom); da = 1'($urandom);
      if (!ca && !da) ca = 1'b1;
      step(ca, 1'($urandom), 8'($urandom_range(0, 15)), 8'($urandom),
           da, 1'($urandom), 8'($urandom_range(0, 15)), 8'($urandom));
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter and sequencer for the shared 8-bit data memory. It sits between the control unit's data-memory strobes (read/write plus DMAR address) and a second requester, a program loader/DMA port. It grants one requester at a time, latches that requester's command, drives the memory for a fixed latency, and returns read data with a one-cycle completion pulse. The CPU sees a stall while its access is pending.

## Interface
- ADDR_W, 8, data-memory address width
- DATA_W, 8, data width
- MEM_LAT, 1, memory strobe cycles per access; legal range 1..7

- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- cpu_rd  in  1  CPU read request; level, held until cpu_done
- cpu_wr  in  1  CPU write request; level, held until cpu_done
- cpu_addr  in  ADDR_W  CPU address
- cpu_wdata  in  DATA_W  CPU write data
- cpu_rdata  out  DATA_W  last CPU read data, registered
- cpu_done  out  1  one-cycle completion pulse
- cpu_stall  out  1  CPU access pending and not yet done
- dma_req  in  1  DMA request; level, held until dma_ack
- dma_we  in  1  1 = write, 0 = read; qualifies dma_req
- dma_addr  in  ADDR_W  DMA address
- dma_wdata  in  DATA_W  DMA write data
- dma_rdata  out  DATA_W  last DMA read data, registered
- dma_ack  out  1  one-cycle completion pulse
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rd  out  1  memory read strobe
- mem_wr  out  1  memory write strobe
- mem_rdata  in  DATA_W  memory read data; valid on the last strobe cycle

## Operation
- States: IDLE, ACCESS, RESP.
- IDLE:
  - If any request is present, arbitrate, latch the winner's owner, address, wdata and direction, load the latency counter with MEM_LAT-1, and go to ACCESS.
  - With no request, stay in IDLE.
- ACCESS:
  - Drive mem_addr/mem_wdata from the latched values, and mem_rd or mem_wr per the latched direction.
  - Decrement the counter each cycle. At count 0 go to RESP. On a read, capture mem_rdata into the owner's rdata register at that same edge.
- RESP:
  - Strobes low. Pulse cpu_done or dma_ack for the owner.
  - Unconditionally return to IDLE. The requester must drop its request at the edge that ends RESP.
- If cpu_rd and cpu_wr are both high, the access is a write.
- Requester inputs are ignored outside IDLE. Changing them mid-access has no effect.
- Default arbitration is fixed priority: the CPU wins all ties.
- cpu_stall = (cpu_rd | cpu_wr) & ~cpu_done, combinational.
- In IDLE, mem_addr and mem_wdata are 0, never high-Z.
- cpu_rdata and dma_rdata hold their value until the next read by the same owner.
- The last_owner register updates on every grant.

## Timing
- A request sampled high at IDLE edge k drives strobes on cycles k+1 .. k+MEM_LAT.
- Done/ack is high on cycle k+MEM_LAT+1. The earliest next grant is at the edge ending cycle k+MEM_LAT+2.
- Back-to-back throughput: one access per MEM_LAT+2 cycles.
- Reset values:
  - state IDLE
  - all strobes, cpu_done and dma_ack = 0
  - cpu_rdata, dma_rdata, mem_addr and mem_wdata = 0
  - last_owner = DMA
  - counter = 0
  - cpu_stall follows its inputs
- Reset asserted mid-ACCESS clears strobes asynchronously, with no done/ack. The interrupted requester re-arbitrates after reset is released.
- Simultaneous new requests in IDLE are resolved by the arbitration rule within the same cycle. The loser waits; it is never dropped.

## Configuration
- DMEM_ARB_FAIR_EN defined: ties use round-robin on last_owner.
  - After a CPU access, DMA wins a tie.
  - After a DMA access, or after reset, the CPU wins a tie.
- DMEM_ARB_FAIR_EN undefined: fixed CPU priority. The last_owner register is still present but unused for arbitration.

## Structure
- Shared header (alongside the existing state/instruction headers):
  - state encodings ARB_IDLE=2'd0, ARB_ACCESS=2'd1, ARB_RESP=2'd2
  - owner encodings OWN_CPU=1'b0, OWN_DMA=1'b1
- Single module. The latency counter and arbiter are inline; no sub-module is warranted.

## Test plan
- Reset, then CPU write: MEM_LAT=1, cpu_wr, addr 0x12, data 0xA5.
  - mem_wr high for 1 cycle with addr 0x12 and wdata 0xA5.
  - cpu_done on the next cycle; cpu_stall high for 2 cycles.
- CPU read, MEM_LAT=3: memory returns 0x3C on the third strobe cycle.
  - mem_rd high for 3 cycles; cpu_rdata = 0x3C; cpu_done on cycle 4.
- Simultaneous cpu_rd(0x01) and dma_req read(0x02), both held.
  - Fixed priority: CPU served first, DMA 3 cycles later (MEM_LAT=1).
  - With DMEM_ARB_FAIR_EN: the second tie round goes to DMA.
- DMA changes dma_addr from 0x40 to 0x41 during ACCESS.
  - mem_addr stays 0x40; dma_ack pulses once.
- Reset asserted on cycle 2 of a MEM_LAT=3 read.
  - mem_rd drops immediately; no cpu_done; state IDLE; cpu_rdata = 0.
  - After reset release, the held request completes normally.
